rc5_host_ctrl: RTL
==================

RC5_HOST_CTRL -- requirements
Module: rc5_host_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: maximum number of cycles to wait for core_done after a command is issued.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of job_count.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request block present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_data  input  32  plaintext or ciphertext block.
REQ-008 in_decrypt  input  1  1 = decrypt, 0 = encrypt.
REQ-009 cfg_key  input  128  cipher key, sampled at acceptance.
REQ-010 cfg_rounds  input  5  round count, 1-indexed (16 = sixteen rounds), sampled at acceptance.
REQ-011 core_encrypt / core_decrypt  output  1 each  level command to the RC5 core.
REQ-012 core_num_rounds  output  5; core_key  output  128; core_d_in  output  32  operands to the core.
REQ-013 core_d_out  input  32; core_done  input  1  core result and completion flag.
REQ-014 resp_valid  output  1; resp_ready  input  1  response handshake.
REQ-015 resp_data  output  32; resp_err  output  1  result and error flag.
REQ-016 job_count  output  CNT_W  count of successful jobs.

Function
REQ-017 States SHALL be IDLE, RUN, RESP and GAP, one-hot or encoded.
REQ-018 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid && in_ready at posedge.
REQ-019 On a transfer, the block SHALL latch in_data, in_decrypt, cfg_key and cfg_rounds into holding registers.
REQ-020 On a transfer, if the latched cfg_rounds is 0 or greater than 16, the block SHALL go to RESP with resp_err=1 and resp_data=32'h0, without issuing a command.
REQ-021 Otherwise the block SHALL go to RUN; from the next cycle it SHALL drive core_d_in, core_key and core_num_rounds from the holding registers.
REQ-022 In RUN, exactly one of core_encrypt/core_decrypt SHALL be held at 1, selected by the latched in_decrypt.
REQ-023 In RUN, operand outputs SHALL stay stable until RUN is exited.
REQ-024 In RUN, a wait counter SHALL increment every cycle starting from 0.
REQ-025 If core_done is sampled 1 in RUN, the block SHALL capture core_d_out into resp_data, set resp_err=0 and go to RESP.
REQ-026 If the wait counter reaches TIMEOUT with core_done still 0, the block SHALL go to RESP with resp_err=1 and resp_data=32'h0.
REQ-027 If core_done and the timeout coincide in the same cycle, core_done SHALL win (success).
REQ-028 core_encrypt and core_decrypt SHALL be 0 in every state except RUN; command deasserts the cycle after done or timeout is sampled.
REQ-029 resp_valid SHALL be 1 exactly in RESP; resp_data and resp_err SHALL be stable while resp_valid=1 && resp_ready=0.
REQ-030 On resp_valid && resp_ready, the block SHALL go to GAP.
REQ-031 On the same resp_valid && resp_ready handshake, job_count SHALL increment by 1 if resp_err=0, wrapping from all-ones to 0.
REQ-032 GAP SHALL last at least one cycle and until core_done is sampled 0, then go to IDLE; a late or stale core_done after a timeout therefore never satisfies a new job.
REQ-033 Request-to-response latency SHALL be core latency + 2 cycles: 1 cycle to accept, core cycles in RUN, 1 cycle capture.
REQ-034 Request-to-response latency for rejected requests SHALL be 1 cycle.
REQ-035 Request throughput SHALL be at most one request per (latency + GAP length + 1) cycles; no request is accepted while a response is pending.

Reset
REQ-036 While rst=0, the block SHALL be asynchronously placed in IDLE.
REQ-037 While rst=0, all outputs SHALL be 0 (in_ready=0, core commands=0, operands=0, resp_valid=0, resp_data=0, resp_err=0, job_count=0), and the wait counter SHALL be 0.
REQ-038 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-039 Reset mid-RUN or mid-RESP SHALL drop the command and response immediately, with no response emitted.

Verification
REQ-040 Core model with done after 20 cycles and d_out=d_in^32'hFFFF0000: encrypt 32'h12345678, rounds 16 -> core_encrypt high 20 cycles, resp_data=32'hEDCB5678, resp_err=0, job_count=1.
REQ-041 Decrypt request with resp_ready held 0 for 10 cycles -> core_decrypt used, core_encrypt never 1, resp_data stable 10 cycles, in_ready=0 throughout.
REQ-042 cfg_rounds=0, then cfg_rounds=17 -> two responses, each 1 cycle after accept, resp_err=1, resp_data=0, core commands never asserted, job_count unchanged.
REQ-043 Core never asserts done, TIMEOUT=255 -> resp_err=1 after 255 RUN cycles; core then asserts done for 5 cycles -> block stays in GAP until done drops, next job completes normally.
REQ-044 rst pulsed low 7 cycles into RUN -> all outputs 0 asynchronously, in_ready=1 one cycle after release, no response issued.
REQ-045 Preload job_count=16'hFFFF via 65535 jobs (or a force) and complete one more job -> job_count=0.

Source files
------------

// File: rtl/rc5_host_ctrl.sv
// Host-side controller for an iterative RC5 core: accepts one block at a time,
// runs the core under a watchdog, and returns either the result or an error.
`timescale 1ns/1ps
module rc5_host_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_decrypt,
  input  logic [127:0]     cfg_key,
  input  logic [4:0]       cfg_rounds,
  output logic             core_encrypt,
  output logic             core_decrypt,
  output logic [4:0]       core_num_rounds,
  output logic [127:0]     core_key,
  output logic [31:0]      core_d_in,
  input  logic [31:0]      core_d_out,
  input  logic             core_done,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_err,
  output logic [CNT_W-1:0] job_count
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_e;

  function automatic logic rounds_ok(input logic [4:0] r);
    return (r != 5'd0) && (r <= 5'd16);
  endfunction

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               in_ready_q, in_ready_d;
  logic               enc_q, enc_d;
  logic               dec_q, dec_d;
  logic [4:0]         rounds_q, rounds_d;
  logic [127:0]       key_q, key_d;
  logic [31:0]        din_q, din_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Next-state and next-output logic; every output is a flop loaded from here.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    in_ready_d   = 1'b0;
    enc_d        = enc_q;
    dec_d        = dec_q;
    rounds_d     = rounds_q;
    key_d        = key_q;
    din_d        = din_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          din_d    = in_data;
          key_d    = cfg_key;
          rounds_d = cfg_rounds;
          wait_d   = {WAIT_W{1'b0}};
          if (rounds_ok(cfg_rounds)) begin
            state_d = RUN;
            enc_d   = ~in_decrypt;
            dec_d   = in_decrypt;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 32'h0000_0000;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
        // A done sampled on the timeout cycle still counts as success.
        if (core_done) begin
          state_d      = RESP;
          enc_d        = 1'b0;
          dec_d        = 1'b0;
          wait_d       = {WAIT_W{1'b0}};
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = core_d_out;
        end else if (wait_q == WAIT_LAST) begin
          state_d      = RESP;
          enc_d        = 1'b0;
          dec_d        = 1'b0;
          wait_d       = {WAIT_W{1'b0}};
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = 32'h0000_0000;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = GAP;
          resp_valid_d = 1'b0;
          if (!resp_err_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = RESP;
        end
      end
      GAP: begin
        // Hold off new work until a stale done from a timed-out job has gone away.
        if (!core_done) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_q       <= {WAIT_W{1'b0}};
      in_ready_q   <= 1'b0;
      enc_q        <= 1'b0;
      dec_q        <= 1'b0;
      rounds_q     <= 5'd0;
      key_q        <= 128'h0;
      din_q        <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      in_ready_q   <= in_ready_d;
      enc_q        <= enc_d;
      dec_q        <= dec_d;
      rounds_q     <= rounds_d;
      key_q        <= key_d;
      din_q        <= din_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign core_encrypt    = enc_q;
  assign core_decrypt    = dec_q;
  assign core_num_rounds = rounds_q;
  assign core_key        = key_q;
  assign core_d_in       = din_q;
  assign resp_valid      = resp_valid_q;
  assign resp_data       = resp_data_q;
  assign resp_err        = resp_err_q;
  assign job_count       = cnt_q;

endmodule
